// File: rtl/tdc_multichannel_core.sv
// Coarse multichannel TDC: shared start, N stop channels, tagged records
// buffered in a small FIFO with a valid/ready readout.
`timescale 1ns/1ps
module tdc_multichannel_core #(
  parameter int CHANNELS    = 4,
  parameter int COUNT_W     = 12,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  localparam int CH_W  = $clog2(CHANNELS),
  localparam int REC_W = CH_W + 1 + COUNT_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                mode,
  input  logic                start_in,
  input  logic [CHANNELS-1:0] stop_in,
  output logic [REC_W-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                overrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];
  localparam logic [COUNT_W-1:0] ALL1 = '1;

  logic [SYNC_STAGES-1:0] start_sync;
  logic                   start_prev;
  logic [CHANNELS-1:0]    stop_sync [SYNC_STAGES];
  logic [CHANNELS-1:0]    stop_prev;

  logic [COUNT_W-1:0]  counter;
  logic                mode_q;
  logic [CHANNELS-1:0] armed;

  logic [CHANNELS-1:0] pend_valid;
  logic [CHANNELS-1:0] pend_ovf;
  logic [COUNT_W-1:0]  pend_cnt [CHANNELS];

  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    head;
  logic [AW-1:0]    tail;
  logic [AW-1:0]    prev_head;
  logic [AW:0]      fifo_cnt;

  logic                start_edge;
  logic [CHANNELS-1:0] stop_edge;
  logic                timeout;
  logic [COUNT_W-1:0]  stamp;
  logic [CH_W-1:0]     sel;
  logic                sel_valid;
  logic                push;
  logic                pop;
  logic [REC_W-1:0]    push_rec;
  logic [CHANNELS-1:0] freed;
  logic [CHANNELS-1:0] hit;
  logic [CHANNELS-1:0] capture;
  logic [CHANNELS-1:0] drop;
  logic [CHANNELS-1:0] disarm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_sync <= '0;
      start_prev <= 1'b0;
      stop_prev  <= '0;
      for (int s = 0; s < SYNC_STAGES; s++)
        stop_sync[s] <= '0;
    end else begin
      start_sync <= {start_sync[SYNC_STAGES-2:0], start_in};
      start_prev <= start_sync[SYNC_STAGES-1];
      stop_sync[0] <= stop_in;
      for (int s = 1; s < SYNC_STAGES; s++)
        stop_sync[s] <= stop_sync[s-1];
      stop_prev <= stop_sync[SYNC_STAGES-1];
    end
  end

  // A start in the same cycle as a stop masks the stop entirely.
  assign start_edge = ena & start_sync[SYNC_STAGES-1] & ~start_prev;
  assign stop_edge  = {CHANNELS{ena & ~start_edge}}
                    & stop_sync[SYNC_STAGES-1] & ~stop_prev;
  assign timeout = busy & ~mode_q & (counter == ALL1) & ~start_edge;

  // The counter is cleared one cycle after the start edge, so the value
  // stamped is one ahead of it to report the true edge-to-edge distance.
  assign stamp = (!mode_q && counter == ALL1) ? ALL1 : counter + 1'b1;

  always_comb begin
    sel = '0;
    sel_valid = 1'b0;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (pend_valid[i]) begin
        sel = CH_W'(i);
        sel_valid = 1'b1;
      end
    end
  end

  assign out_valid = (fifo_cnt != '0);
  assign pop       = out_valid & out_ready;
  assign push      = sel_valid & ((fifo_cnt != DEPTH_C) | pop);
  assign push_rec  = {sel, pend_ovf[sel], pend_cnt[sel]};

  always_comb begin
    freed   = '0;
    hit     = '0;
    capture = '0;
    drop    = '0;
    disarm  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      freed[i]   = push && (sel == CH_W'(i));
      hit[i]     = armed[i] & (stop_edge[i] | timeout);
      capture[i] = hit[i] & (~pend_valid[i] | freed[i]);
      drop[i]    = hit[i] & pend_valid[i] & ~freed[i];
      disarm[i]  = hit[i] & ~mode_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= '0;
      mode_q  <= 1'b0;
      armed   <= '0;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else if (start_edge) begin
      counter <= '0;
      mode_q  <= mode;
      armed   <= '1;
      busy    <= 1'b1;
      overrun <= 1'b0;
    end else begin
      if (busy && ena) begin
        if (mode_q)
          counter <= counter + 1'b1;
        else if (counter != ALL1)
          counter <= counter + 1'b1;
      end
      if (busy && !mode_q && armed == '0)
        busy <= 1'b0;
      armed <= armed & ~disarm;
      if (|drop)
        overrun <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= '0;
      pend_ovf   <= '0;
      for (int i = 0; i < CHANNELS; i++)
        pend_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        if (capture[i]) begin
          pend_valid[i] <= 1'b1;
          pend_ovf[i]   <= timeout;
          pend_cnt[i]   <= stamp;
        end else if (freed[i]) begin
          pend_valid[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head     <= '0;
      tail     <= '0;
      fifo_cnt <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (push) begin
        mem[tail] <= push_rec;
        tail <= tail + 1'b1;
      end
      if (pop)
        head <= head + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // When empty, the slot behind head is the last record popped.
  assign prev_head = head - 1'b1;
  assign out_data  = out_valid ? mem[head] : mem[prev_head];

endmodule

// File: tb/tb_tdc_multichannel_core.sv
// Directed bench for tdc_multichannel_core: modes, timeout, wrap,
// backpressure, start/stop collisions and asynchronous reset.
`timescale 1ns/1ps
module tb_tdc_multichannel_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b1;
  logic        mode = 1'b0;
  logic        start_in = 1'b0;
  logic [3:0]  stop_in = '0;
  logic [14:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        busy;
  logic        overrun;

  int total = 0;
  int bad = 0;
  int now = 0;
  int t0 = 0;

  tdc_multichannel_core dut (
    .clk(clk),
    .rst_n(rst_n),
    .ena(ena),
    .mode(mode),
    .start_in(start_in),
    .stop_in(stop_in),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy(busy),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] rec(int ch, int ov, int cnt);
    return {ch[1:0], ov[0], cnt[11:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      now++;
    end
  endtask

  task automatic go(input int k);
    while (now < t0 + k) tick(1);
  endtask

  task automatic start_sess(input logic m, input logic [3:0] smask);
    mode = m;
    start_in = 1'b1;
    stop_in = smask;
    t0 = now;
    tick(1);
    start_in = 1'b0;
    stop_in = '0;
  endtask

  task automatic pulse(input logic [3:0] m, input int k);
    go(k);
    stop_in = m;
    tick(1);
    stop_in = '0;
  endtask

  task automatic pop_expect(input string tag, input logic [14:0] exp);
    int n = 0;
    while (out_valid !== 1'b1 && n < 64) begin
      tick(1);
      n++;
    end
    check({tag, "_v"}, {31'd0, out_valid}, 32'd1);
    check(tag, {17'd0, out_data}, {17'd0, exp});
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
  endtask

  initial begin
    tick(2);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ovr", {31'd0, overrun}, 32'd0);
    check("rst_data", {17'd0, out_data}, 32'd0);
    rst_n = 1'b1;
    tick(4);

    // single-shot, four channels, ch1/ch2 coincident
    start_sess(1'b0, 4'b0000);
    go(10);
    check("m0_busy_on", {31'd0, busy}, 32'd1);
    pulse(4'b0001, 10);
    pulse(4'b0110, 25);
    go(30);
    check("m0_busy_mid", {31'd0, busy}, 32'd1);
    pulse(4'b1000, 40);
    go(50);
    check("m0_busy_off", {31'd0, busy}, 32'd0);
    pop_expect("m0_r0", rec(0, 0, 10));
    pop_expect("m0_r1", rec(1, 0, 25));
    pop_expect("m0_r2", rec(2, 0, 25));
    pop_expect("m0_r3", rec(3, 0, 40));
    check("m0_empty", {31'd0, out_valid}, 32'd0);
    check("m0_hold", {17'd0, out_data}, {17'd0, rec(3, 0, 40)});

    // timeout with only ch2 stopping
    start_sess(1'b0, 4'b0000);
    pulse(4'b0100, 100);
    go(4000);
    check("to_busy_on", {31'd0, busy}, 32'd1);
    go(4120);
    check("to_busy_off", {31'd0, busy}, 32'd0);
    pop_expect("to_r0", rec(2, 0, 100));
    pop_expect("to_r1", rec(0, 1, 4095));
    pop_expect("to_r2", rec(1, 1, 4095));
    pop_expect("to_r3", rec(3, 1, 4095));
    check("to_empty", {31'd0, out_valid}, 32'd0);

    // continuous mode with counter wrap
    start_sess(1'b1, 4'b0000);
    pulse(4'b0001, 5);
    pulse(4'b0001, 9);
    pulse(4'b0001, 4100);
    go(4120);
    check("m1_busy", {31'd0, busy}, 32'd1);
    pop_expect("m1_r0", rec(0, 0, 5));
    pop_expect("m1_r1", rec(0, 0, 9));
    pop_expect("m1_r2", rec(0, 0, 4));
    check("m1_empty", {31'd0, out_valid}, 32'd0);

    // start and ch1 stop together, then a restart mid-session
    start_sess(1'b0, 4'b0010);
    pulse(4'b0001, 5);
    go(10);
    start_sess(1'b0, 4'b0000);
    pulse(4'b0010, 3);
    pulse(4'b1100, 10);
    go(20);
    check("col_busy", {31'd0, busy}, 32'd1);
    pop_expect("col_r0", rec(0, 0, 5));
    pop_expect("col_r1", rec(1, 0, 3));
    pop_expect("col_r2", rec(2, 0, 10));
    pop_expect("col_r3", rec(3, 0, 10));
    check("col_empty", {31'd0, out_valid}, 32'd0);

    // backpressure: FIFO full, two pending held, one dropped
    start_sess(1'b1, 4'b0000);
    pulse(4'b1111, 10);
    pulse(4'b0011, 20);
    go(28);
    check("bp_valid", {31'd0, out_valid}, 32'd1);
    check("bp_ovr0", {31'd0, overrun}, 32'd0);
    pulse(4'b0001, 30);
    go(36);
    check("bp_ovr1", {31'd0, overrun}, 32'd1);
    pop_expect("bp_r0", rec(0, 0, 10));
    pop_expect("bp_r1", rec(1, 0, 10));
    pop_expect("bp_r2", rec(2, 0, 10));
    pop_expect("bp_r3", rec(3, 0, 10));
    pop_expect("bp_r4", rec(0, 0, 20));
    pop_expect("bp_r5", rec(1, 0, 20));
    check("bp_empty", {31'd0, out_valid}, 32'd0);

    // asynchronous reset with a record waiting and a live session
    pulse(4'b0100, 50);
    go(60);
    check("ar_pre_v", {31'd0, out_valid}, 32'd1);
    check("ar_pre_b", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    check("ar_valid", {31'd0, out_valid}, 32'd0);
    check("ar_busy", {31'd0, busy}, 32'd0);
    check("ar_ovr", {31'd0, overrun}, 32'd0);
    check("ar_data", {17'd0, out_data}, 32'd0);
    tick(1);
    stop_in = 4'b0001;
    tick(1);
    stop_in = '0;
    tick(10);
    check("ar_nostop", {31'd0, out_valid}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tdc_multichannel_core.md
Name: tdc_multichannel_core

Overview:
Parametrised coarse time-to-digital converter core that generalises the single-channel microtile TDC to N stop channels with a shared start. It measures the clk-cycle distance from a synchronised start edge to each channel's synchronised stop edge, and supports two modes: single-shot with timeout, and continuous free-running timestamp. Results are tagged records buffered in a small FIFO with a valid/ready readout. It sits behind the tt_um top-level wrapper, which maps pins to its ports.

Parameters:
CHANNELS, 4, number of stop channels (2..8)
COUNT_W, 12, coarse counter width in bits
FIFO_DEPTH, 4, result FIFO entries (power of 2)
SYNC_STAGES, 2, synchroniser flops on start_in and each stop_in bit (>=2)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ena  in  1  block enable; when low, no edges are accepted and the counter holds
mode  in  1  0 = single-shot, 1 = continuous; latched only on a start edge
start_in  in  1  asynchronous start event (rising edge)
stop_in  in  CHANNELS  asynchronous stop events, one bit per channel (rising edge)
out_data  out  CH_W+1+COUNT_W  record {chan_id, ovf, count}; CH_W = clog2(CHANNELS)
out_valid  out  1  FIFO head is valid
out_ready  in  1  consumer accepts the head when high with out_valid
busy  out  1  session active
overrun  out  1  sticky: a stop was dropped

Behaviour:
- Reset: counter=0, all channels disarmed, pending slots empty, FIFO empty, out_valid=0, out_data=0, busy=0, overrun=0, mode_q=0, synchronisers=0.
- Edges: each input passes through SYNC_STAGES flops. Edge = last stage high and the previous-cycle copy low. Start and stop paths have identical latency, so the latency cancels.
- Start edge at cycle T0 (ena=1):
  - counter<=0; mode_q<=mode; all channels armed; busy<=1; overrun<=0.
  - Pending slots and FIFO contents are kept.
- Counter: increments by 1 each cycle while busy and ena.
  - Mode 0: saturates at 2^COUNT_W-1.
  - Mode 1: wraps to 0.
- Stop edge on armed channel i at cycle Ts:
  - Pending slot i <= {i, 0, counter}, with counter value = Ts-T0 modulo wrap.
  - Mode 0 disarms channel i. Mode 1 leaves it armed, so each later edge yields a new record.
- Stop edge on an unarmed channel: ignored.
- Stop edge while pending slot i is still full: record dropped; overrun<=1.
- Timeout (mode 0): on the cycle the counter reaches all-ones, every still-armed channel gets pending {i, 1, all-ones} and is disarmed.
- busy (mode 0) falls the cycle after the last channel disarms. Mode 1 stays busy until reset.
- Start edge and stop edge in the same cycle: start wins; the stop is ignored.
- A start edge during an active session restarts it (re-arm all).
- Arbiter: each cycle the lowest-index full pending slot is pushed to the FIFO if not full (or if a pop happens the same cycle). Its slot is cleared at that edge.
  - Push-to-out_valid latency: 1 cycle.
  - Stop-pin to out_valid with an idle FIFO: SYNC_STAGES+2 cycles.
- FIFO: circular buffer with a count register.
  - out_data = head, combinational from the registered array.
  - Pop when out_valid&&out_ready. Simultaneous push and pop when full is allowed.
  - Empty: out_valid=0 and out_data holds its last value.
  - Full: pending slots hold; this is backpressure, not loss.
- ena=0: edge detection is gated, the counter holds, and FIFO pop/push continue. Synchronisers keep running, so no false edge occurs on re-enable.
- Asynchronous reset mid-session returns every register to its reset value immediately.

Test Plan:
- Mode 0: start at t, stops on ch0/1/2/3 after 10/25/25/40 cycles -> 4 records, ovf=0, counts 10, 25, 25, 40. Ch1 precedes ch2 on the same cycle. busy falls after ch3.
- Timeout: mode 0, COUNT_W=12, stop only ch2 at 100 -> records {2,0,100}, then {0,1,4095}, {1,1,4095}, {3,1,4095}; busy=0.
- Mode 1: ch0 stop edges at 5, 9, 4100 after start -> counts 5, 9, 4 (wrap); busy stays 1.
- Backpressure: out_ready=0, 6 stop records -> 4 in FIFO plus pending held. Any further stop on a held channel sets overrun=1. Releasing out_ready drains the records in order with no loss of the held ones.
- Collisions: start and stop on ch1 in the same cycle -> no ch1 record. A second start mid-session re-arms, and counts restart from 0.
- Reset mid-session: rst_n low for 1 ns while busy -> out_valid=0, busy=0, overrun=0 immediately. A stop afterwards yields no record.
